wb_frame_reader: RTL and testbench
==================================

Name: wb_frame_reader

Overview:
- Wishbone classic master: the requester side of the framebuffer memory slave.
- Sequentially reads one frame of 32-bit pixel words from the framebuffer, starting at BASE_ADR.
- Pushes each word into the display pixel FIFO, applying FIFO back-pressure.
- Sits between the Wishbone interconnect/memory and the video output path; one frame is read per frame_sync pulse.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE_ADR, 32'h0000_0000, byte address of pixel 0; must be 4-byte aligned.

Ports:
- wb_m.clk  in  1  clock; carried in the wshb_if.master interface.
- wb_m.rst  in  1  reset; synchronous, active-high; carried in the wshb_if.master interface.
- wb_m.cyc  out  1  bus cycle.
- wb_m.stb  out  1  strobe.
- wb_m.we  out  1  always 0 (read-only master).
- wb_m.adr  out  32  byte address.
- wb_m.sel  out  4  always 4'hF.
- wb_m.cti  out  3  always 3'b000 (classic).
- wb_m.bte  out  2  always 2'b00.
- wb_m.dat_ms  out  32  always 0.
- wb_m.dat_sm  in  32  read data.
- wb_m.ack  in  1  slave acknowledge.
- frame_sync  in  1  one-cycle pulse requesting a frame start.
- fifo_write  out  1  pixel FIFO write enable.
- fifo_wdata  out  32  pixel word.
- fifo_wfull  in  1  pixel FIFO full.
- sync_err  out  1  sticky: frame_sync arrived while a frame was still being read.

Behaviour:
- Reset values: cyc=0, stb=0, adr=BASE_ADR, fifo_write=0, fifo_wdata=0, sync_err=0. Internal pixel counter = 0, state = WAIT_SYNC.
- Reset taken mid-transfer drops cyc/stb on the next edge; a late ack after reset is ignored.
- State WAIT_SYNC: bus idle. frame_sync=1 → counter=0, adr=BASE_ADR, go to READ.
- State READ, issuing a request:
  - While fifo_wfull=1: cyc=stb=0.
  - When fifo_wfull=0: assert cyc=stb=1 with adr = BASE_ADR + 4*counter.
  - Hold cyc, stb and adr stable until ack.
- State READ, on the ack cycle:
  - Drive fifo_write=1 and fifo_wdata=dat_sm combinationally in that same cycle.
  - Clock edge: counter+1, adr+4, cyc/stb deassert for at least one cycle.
  - The FIFO cannot fill between request and ack because this block is its only writer, so ack data is never dropped.
- Throughput: one word per 3 cycles with a 1-cycle-latency read slave (request, ack, gap).
- Last word: on ack with counter = HDISP*VDISP-1 → counter=0, adr=BASE_ADR, go to WAIT_SYNC.
- frame_sync during READ (not on the last ack):
  - Set sync_err=1; it clears only on reset.
  - Any outstanding request still completes: wait for ack; that word is discarded, fifo_write=0.
  - Then restart at counter=0, adr=BASE_ADR, stay in READ.
- frame_sync coincident with the last ack: the last word is written, then the block restarts directly in READ with no WAIT_SYNC cycle; sync_err unchanged.
- ack while cyc=0 is ignored.
- Counter width: $clog2(HDISP*VDISP). Address arithmetic is 32-bit and wraps modulo 2^32 (not expected in use).
- fifo_write is never asserted outside an ack cycle with cyc=stb=1.

Decomposition:
- Package fb_pkg holds:
  - typedef enum state_t {WAIT_SYNC, READ, DRAIN}. DRAIN = waiting for the ack of an aborted request.
  - localparam FRAME_WORDS = HDISP*VDISP.
  - localparam WORD_BYTES = 4.
- Optional sub-module fb_addr_gen: the pixel counter plus address register, with load (frame start) and inc (ack) controls. The FSM and bus logic stay in the top module.

Test Plan:
- Run with HDISP=4, VDISP=2 against the 1-cycle-latency BRAM model preloaded with mem[i]=i+100; pulse frame_sync → 8 FIFO writes, values 100..107, adr 0x00..0x1C in steps of 4, then bus idle in WAIT_SYNC.
- Hold fifo_wfull=1 for 10 cycles after the 3rd word → cyc=0 throughout; reading resumes at adr 0x0C with no lost or duplicated word.
- Slave ack delayed 5 cycles → adr/stb stable for all 5 cycles; exactly one fifo_write on ack.
- frame_sync at word 5 with its request outstanding → word 5 not written, sync_err=1, next request at adr=BASE_ADR.
- frame_sync on the same cycle as the 8th ack → word 107 written; next cycle-after-gap request at BASE_ADR; sync_err stays 0.
- Reset asserted while stb=1 → next cycle cyc=stb=0, all outputs at reset values; no activity until frame_sync.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the Wishbone framebuffer reader.
// Frame geometry defaults live here; the top may override them.
package fb_pkg;

   localparam int HDISP_DEF   = 800;
   localparam int VDISP_DEF   = 480;
   localparam int FRAME_WORDS = HDISP_DEF * VDISP_DEF;
   localparam int WORD_BYTES  = 4;

   typedef enum logic [1:0] {
      WAIT_SYNC,
      READ,
      DRAIN
   } state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle with master and slave views.
// Clock and reset travel with the bus.
interface wshb_if (
   input logic clk,
   input logic rst
);

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        ack;

   modport master (
      input  clk, rst, dat_sm, ack,
      output cyc, stb, we, adr, sel, cti, bte, dat_ms
   );

   modport slave (
      input  clk, rst, cyc, stb, we, adr, sel, cti, bte, dat_ms,
      output dat_sm, ack
   );

endinterface

// File: rtl/fb_addr_gen.sv
// Pixel counter and byte address register for one frame.
// load restarts the frame; inc advances one word.
module fb_addr_gen
   import fb_pkg::*;
#(
   parameter int          NWORDS   = FRAME_WORDS,
   parameter int          CW       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1,
   parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        inc_i,
   output logic [31:0] adr_o,
   output logic        last_o
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   adr_q, adr_d;

   always_comb begin
      cnt_d = cnt_q;
      adr_d = adr_q;
      if (load_i) begin
         cnt_d = '0;
         adr_d = BASE_ADR;
      end else if (inc_i) begin
         cnt_d = cnt_q + CW'(1);
         adr_d = adr_q + 32'(WORD_BYTES);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         adr_q <= BASE_ADR;
      end else begin
         cnt_q <= cnt_d;
         adr_q <= adr_d;
      end
   end

   assign adr_o  = adr_q;
   assign last_o = (cnt_q == CW'(NWORDS - 1));

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone classic read master streaming one frame of pixel words
// from the framebuffer into the display FIFO per frame_sync.
module wb_frame_reader
   import fb_pkg::*;
#(
   parameter int          HDISP    = HDISP_DEF,
   parameter int          VDISP    = VDISP_DEF,
   parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
   wshb_if.master      wb_m,
   input  logic        frame_sync,
   output logic        fifo_write,
   output logic [31:0] fifo_wdata,
   input  logic        fifo_wfull,
   output logic        sync_err
);

   localparam int NWORDS = HDISP * VDISP;
   localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   state_t      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        err_q, err_d;
   logic        load, inc, last, ack;
   logic [31:0] adr;

   assign ack = wb_m.ack && !wb_m.rst;

   fb_addr_gen #(
      .NWORDS   (NWORDS),
      .CW       (CW),
      .BASE_ADR (BASE_ADR)
   ) u_addr (
      .clk_i  (wb_m.clk),
      .rst_i  (wb_m.rst),
      .load_i (load),
      .inc_i  (inc),
      .adr_o  (adr),
      .last_o (last)
   );

   always_ff @(posedge wb_m.clk) begin
      if (wb_m.rst) begin
         state_q <= WAIT_SYNC;
         cyc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      err_d      = err_q;
      load       = 1'b0;
      inc        = 1'b0;
      fifo_write = 1'b0;
      unique case (state_q)
         WAIT_SYNC: begin
            cyc_d = 1'b0;
            if (frame_sync) begin
               load    = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            if (cyc_q) begin
               if (ack) begin
                  cyc_d = 1'b0;
                  if (last) begin
                     fifo_write = 1'b1;
                     load       = 1'b1;
                     if (!frame_sync) state_d = WAIT_SYNC;
                  end else if (frame_sync) begin
                     // restart request lands on an ack: drop this word
                     err_d = 1'b1;
                     load  = 1'b1;
                  end else begin
                     fifo_write = 1'b1;
                     inc        = 1'b1;
                  end
               end else if (frame_sync) begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end
            end else begin
               cyc_d = !fifo_wfull;
               if (frame_sync) begin
                  err_d = 1'b1;
                  load  = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (ack) begin
               cyc_d   = 1'b0;
               load    = 1'b1;
               state_d = READ;
            end
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = WAIT_SYNC;
         end
      endcase
   end

   assign fifo_wdata  = fifo_write ? wb_m.dat_sm : 32'h0;
   assign sync_err    = err_q;
   assign wb_m.cyc    = cyc_q;
   assign wb_m.stb    = cyc_q;
   assign wb_m.we     = 1'b0;
   assign wb_m.adr    = adr;
   assign wb_m.sel    = 4'hF;
   assign wb_m.cti    = 3'b000;
   assign wb_m.bte    = 2'b00;
   assign wb_m.dat_ms = 32'h0;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Randomised scoreboard bench for wb_frame_reader on a 4x2 frame
// against a BRAM-like slave holding mem[i] = i + 100.
module tb_wb_frame_reader;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int NW = H * V;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_sync = 1'b0;
   logic        full_force = 1'b0;
   logic        full_rand = 1'b0;
   logic        fifo_wfull;
   logic        fifo_write;
   logic [31:0] fifo_wdata;
   logic        sync_err;

   always #5 clk = ~clk;

   assign fifo_wfull = full_force | full_rand;

   wshb_if wb (.clk(clk), .rst(rst));

   wb_frame_reader #(
      .HDISP    (H),
      .VDISP    (V),
      .BASE_ADR (32'h0000_0000)
   ) dut (
      .wb_m       (wb),
      .frame_sync (frame_sync),
      .fifo_write (fifo_write),
      .fifo_wdata (fifo_wdata),
      .fifo_wfull (fifo_wfull),
      .sync_err   (sync_err)
   );

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   wr_t  expq[$];
   int   total = 0;
   int   bad = 0;
   int   wr_cnt = 0;
   logic exp_err = 1'b0;
   int   lat_lo = 0;
   int   lat_hi = 0;
   bit   stray = 1'b0;
   bit   rand_full = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp_v);
      end
   endtask

   // Reference model: a frame is the word sequence i -> (4*i, 100+i).
   function automatic void push_frame();
      for (int i = 0; i < NW; i++)
         expq.push_back('{adr: 32'(4 * i), dat: 32'(100 + i)});
   endfunction

   // Slave: ack arrives lat+1 cycles after the request is first seen.
   initial begin : slave
      logic [31:0] mem [NW];
      int cnt;
      int lat;
      bit r;
      cnt = 0;
      lat = 0;
      for (int i = 0; i < NW; i++) mem[i] = 32'(100 + i);
      wb.ack    = 1'b0;
      wb.dat_sm = 32'h0;
      forever begin
         @(negedge clk);
         r = wb.cyc && wb.stb && !wb.ack && !rst;
         if (!r) begin
            cnt = 0;
            lat = int'($urandom_range(lat_hi, lat_lo));
         end
         @(posedge clk);
         #1;
         wb.ack = 1'b0;
         if (stray) begin
            wb.ack    = 1'b1;
            wb.dat_sm = 32'hDEAD_BEEF;
            stray     = 1'b0;
         end else if (r) begin
            if (cnt >= lat) begin
               wb.ack    = 1'b1;
               wb.dat_sm = mem[wb.adr[4:2]];
               cnt       = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   initial begin : full_gen
      forever begin
         @(posedge clk);
         #2;
         if (rand_full && !wb.cyc) full_rand = ($urandom_range(0, 2) == 0);
         else full_rand = 1'b0;
      end
   end

   initial begin : monitor
      logic        cyc_p, ack_p, rst_p, full_p;
      logic [31:0] adr_p;
      wr_t         e;
      cyc_p  = 1'b0;
      ack_p  = 1'b0;
      rst_p  = 1'b1;
      full_p = 1'b0;
      adr_p  = 32'h0;
      forever begin
         @(negedge clk);
         if (fifo_write) begin
            wr_cnt++;
            chk1("wr_legal", wb.cyc && wb.stb && wb.ack, 1'b1);
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got adr %0h data %0h expected none",
                        wb.adr, fifo_wdata);
            end else begin
               e = expq.pop_front();
               chk("wr_data", fifo_wdata, e.dat);
               chk("wr_adr", wb.adr, e.adr);
            end
         end
         if (cyc_p && !ack_p && !rst_p && !rst) begin
            chk1("hold_cycstb", wb.cyc && wb.stb, 1'b1);
            chk("hold_adr", wb.adr, adr_p);
         end
         if (wb.cyc && !cyc_p) chk1("rise_while_full", full_p, 1'b0);
         cyc_p  = wb.cyc;
         ack_p  = wb.ack;
         rst_p  = rst;
         adr_p  = wb.adr;
         full_p = fifo_wfull;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse_sync();
      @(posedge clk);
      #2 frame_sync = 1'b1;
      @(posedge clk);
      #2 frame_sync = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (expq.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, expq.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_writes(input int target);
      int n = 0;
      @(negedge clk);
      while (wr_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk1("wait_writes", wr_cnt >= target, 1'b1);
   endtask

   task automatic wait_req(input logic [31:0] a);
      int n = 0;
      @(negedge clk);
      while (!(wb.cyc && wb.adr == a) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk1("wait_req", wb.cyc && wb.adr == a, 1'b1);
   endtask

   task automatic wait_cyc(input logic v);
      int n = 0;
      @(negedge clk);
      while (wb.cyc !== v && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk1("wait_cyc", wb.cyc, v);
   endtask

   task automatic check_idle(input string nm, input int k);
      int n = 0;
      repeat (k) begin
         @(negedge clk);
         if (wb.cyc || wb.stb) n++;
      end
      chk(nm, n, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      expq.delete();
      exp_err = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin : stim
      int base;
      int k;
      bit abort;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_cyc", wb.cyc, 1'b0);
      chk1("rst_stb", wb.stb, 1'b0);
      chk("rst_adr", wb.adr, 32'h0);
      chk1("rst_fw", fifo_write, 1'b0);
      chk("rst_wdata", fifo_wdata, 32'h0);
      chk1("rst_err", sync_err, 1'b0);
      chk1("we", wb.we, 1'b0);
      chk("sel", 32'(wb.sel), 32'hF);
      chk("cti", 32'(wb.cti), 32'h0);
      chk("bte", 32'(wb.bte), 32'h0);
      chk("dat_ms", wb.dat_ms, 32'h0);
      @(posedge clk);
      #2 rst = 1'b0;
      check_idle("idle_after_reset", 5);

      // plain frame
      push_frame();
      pulse_sync();
      wait_done("t1_done");
      check_idle("t1_idle", 10);
      chk1("t1_err", sync_err, 1'b0);

      // FIFO full after the third word
      base = wr_cnt;
      push_frame();
      pulse_sync();
      wait_writes(base + 3);
      full_force = 1'b1;
      check_idle("t2_full_idle", 10);
      @(posedge clk);
      #2 full_force = 1'b0;
      wait_done("t2_done");

      // slow slave
      lat_lo = 5;
      lat_hi = 5;
      push_frame();
      pulse_sync();
      begin
         int n = 0;
         wait_req(32'h0);
         while (!wb.ack && n < 50) begin
            n++;
            @(negedge clk);
         end
         chk("t3_wait_cycles", n, 6);
      end
      wait_done("t3_done");
      lat_lo = 0;
      lat_hi = 0;

      // abort with word 5 outstanding
      lat_lo = 2;
      lat_hi = 2;
      push_frame();
      pulse_sync();
      wait_req(32'h14);
      expq.delete();
      push_frame();
      exp_err = 1'b1;
      pulse_sync();
      wait_cyc(1'b0);
      wait_cyc(1'b1);
      chk("t4_restart_adr", wb.adr, 32'h0);
      chk1("t4_err", sync_err, exp_err);
      wait_done("t4_done");
      chk1("t4_err_sticky", sync_err, exp_err);
      lat_lo = 0;
      lat_hi = 0;

      do_reset();
      @(negedge clk);
      chk1("t5_err_cleared", sync_err, 1'b0);

      // sync on the last ack
      push_frame();
      pulse_sync();
      wait_req(32'h1C);
      push_frame();
      pulse_sync();
      @(negedge clk);
      chk1("t5_gap", wb.cyc, 1'b0);
      @(negedge clk);
      chk1("t5_restart_cyc", wb.cyc, 1'b1);
      chk("t5_restart_adr", wb.adr, 32'h0);
      wait_done("t5_done");
      chk1("t5_err", sync_err, 1'b0);
      check_idle("t5_idle", 6);

      // reset while a request is outstanding, plus a stray late ack
      lat_lo = 3;
      lat_hi = 3;
      push_frame();
      pulse_sync();
      wait_req(32'h08);
      rst = 1'b1;
      stray = 1'b1;
      expq.delete();
      exp_err = 1'b0;
      @(negedge clk);
      chk1("t6_cyc", wb.cyc, 1'b0);
      chk1("t6_stb", wb.stb, 1'b0);
      chk("t6_adr", wb.adr, 32'h0);
      chk1("t6_fw", fifo_write, 1'b0);
      chk("t6_wdata", fifo_wdata, 32'h0);
      chk1("t6_err", sync_err, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      check_idle("t6_idle", 10);
      lat_lo = 0;
      lat_hi = 0;

      // randomised frames: latency, FIFO back-pressure, aborts
      rand_full = 1'b1;
      for (int it = 0; it < 8; it++) begin
         abort = ($urandom_range(0, 2) == 0);
         lat_hi = int'($urandom_range(0, 3));
         lat_lo = 0;
         if (abort) begin
            lat_lo = 1;
            if (lat_hi < 1) lat_hi = 1;
         end
         push_frame();
         pulse_sync();
         if (abort) begin
            k = int'($urandom_range(1, NW - 1));
            wait_req(32'(4 * k));
            expq.delete();
            push_frame();
            exp_err = 1'b1;
            pulse_sync();
         end
         wait_done("rnd_done");
         chk1("rnd_err", sync_err, exp_err);
      end
      rand_full = 1'b0;
      lat_lo = 0;
      lat_hi = 0;
      repeat (2) @(posedge clk);
      check_idle("rnd_idle", 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
